// File: rtl/fifo_request_arbiter_pkg.sv
// Shared definitions for the FIFO request arbiter: FSM state encoding and a
// constant clog2 helper used to size pointer fields.
package fifo_request_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2
   } arb_state_t;

   // Ceiling log2 for parameter elaboration; returns at least 1 so a pointer
   // field never collapses to zero width.
   function automatic int clog2_f(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      for (int i = 0; i < 32; i++) begin
         if (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
         end
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_request_arbiter_if.sv
// Bus bundle between the producers / fifo_queue and the arbiter.
//   slave  : arbiter view (consumes producer requests and the FIFO ack)
//   master : environment view (producers, fifo_queue, monitors)
// Signals:
//   request_packed_in        producer i data at [i*W +: W]
//   request_valid_packed_in  producer valid bits
//   issue_ack_packed_out     one-hot, one-cycle ack back to producers
//   request_out              entry to fifo_queue request_in
//   request_valid_out        to fifo_queue request_valid_in
//   issue_ack_in             from fifo_queue issue_ack_out
//   grant_index_out          current / last granted producer
//   busy_out                 high while in ISSUE or ACK
interface fifo_request_arbiter_if #(
   parameter int NUM_REQUESTER               = 4,
   parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2,
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = 64
);
   logic [NUM_REQUESTER*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_packed_in;
   logic [NUM_REQUESTER-1:0]                            request_valid_packed_in;
   logic [NUM_REQUESTER-1:0]                            issue_ack_packed_out;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]               request_out;
   logic                                                request_valid_out;
   logic                                                issue_ack_in;
   logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0]              grant_index_out;
   logic                                                busy_out;

   modport slave (
      input  request_packed_in,
      input  request_valid_packed_in,
      input  issue_ack_in,
      output issue_ack_packed_out,
      output request_out,
      output request_valid_out,
      output grant_index_out,
      output busy_out
   );

   modport master (
      output request_packed_in,
      output request_valid_packed_in,
      output issue_ack_in,
      input  issue_ack_packed_out,
      input  request_out,
      input  request_valid_out,
      input  grant_index_out,
      input  busy_out
   );
endinterface

// File: rtl/fifo_request_arbiter_rr_priority_select.sv
// Combinational round-robin priority select.
// Ports:
//   valid_in          request vector
//   last_grant_ptr_in index granted most recently
//   sel_out           first set bit scanning upward from last_grant_ptr_in+1
//   any_valid_out     at least one valid bit set
module rr_priority_select #(
   parameter int NUM_REQUESTER               = 4,
   parameter int REQUESTER_PTR_WIDTH_IN_BITS = 2
) (
   input  logic [NUM_REQUESTER-1:0]               valid_in,
   input  logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] last_grant_ptr_in,
   output logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] sel_out,
   output logic                                   any_valid_out
);

   // Offsets are visited from farthest to nearest so the nearest valid
   // candidate is the last to write sel_out. Wrap uses an explicit compare
   // so non-power-of-two requester counts work.
   always_comb begin
      int                                   idx;
      logic [REQUESTER_PTR_WIDTH_IN_BITS-1:0] idx_p;
      sel_out       = '0;
      any_valid_out = 1'b0;
      for (int off = NUM_REQUESTER; off >= 1; off--) begin
         idx = int'(last_grant_ptr_in) + off;
         if (idx >= NUM_REQUESTER) begin
            idx = idx - NUM_REQUESTER;
         end
         idx_p = REQUESTER_PTR_WIDTH_IN_BITS'(idx);
         if (valid_in[idx_p]) begin
            sel_out       = idx_p;
            any_valid_out = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_request_arbiter.sv
// Round-robin arbiter sharing one fifo_queue write port among producers.
// Ports:
//   clk_in    clock, all logic on posedge
//   reset_in  synchronous active-low reset
//   arb_bus   producer / FIFO bundle (slave modport), all outputs registered
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | arbitrate; latch the selected entry and raise request_valid_out
// ST_ISSUE | hold the latched entry until the FIFO acks
// ST_ACK   | one-cycle ack to the granted producer; no arbitration
module fifo_request_arbiter
   import fifo_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTER               = 4,
   parameter int REQUESTER_PTR_WIDTH_IN_BITS = clog2_f(NUM_REQUESTER),
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS  = 64
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   fifo_request_arbiter_if.slave arb_bus
);

   localparam int W  = SINGLE_ENTRY_WIDTH_IN_BITS;
   localparam int PW = REQUESTER_PTR_WIDTH_IN_BITS;

   arb_state_t             state_q, state_d;
   logic [W-1:0]           req_q, req_d;
   logic                   rv_q, rv_d;
   logic [NUM_REQUESTER-1:0] ack_q, ack_d;
   logic [PW-1:0]          grant_q, grant_d;
   logic [PW-1:0]          last_ptr_q, last_ptr_d;
   logic                   busy_q, busy_d;

   logic [PW-1:0]          sel;
   logic                   any_valid;

   rr_priority_select #(
      .NUM_REQUESTER               (NUM_REQUESTER),
      .REQUESTER_PTR_WIDTH_IN_BITS (PW)
   ) u_select (
      .valid_in          (arb_bus.request_valid_packed_in),
      .last_grant_ptr_in (last_ptr_q),
      .sel_out           (sel),
      .any_valid_out     (any_valid)
   );

   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         rv_q       <= 1'b0;
         ack_q      <= '0;
         grant_q    <= '0;
         last_ptr_q <= PW'(NUM_REQUESTER - 1);
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         rv_q       <= rv_d;
         ack_q      <= ack_d;
         grant_q    <= grant_d;
         last_ptr_q <= last_ptr_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (any_valid)            state_d = ST_ISSUE;
         ST_ISSUE: if (arb_bus.issue_ack_in) state_d = ST_ACK;
         ST_ACK:                             state_d = ST_IDLE;
         default:                            state_d = ST_IDLE;
      endcase
   end

   // Computes the next value of every registered output.
   always_comb begin
      req_d      = req_q;
      rv_d       = rv_q;
      ack_d      = ack_q;
      grant_d    = grant_q;
      last_ptr_d = last_ptr_q;
      case (state_q)
         ST_IDLE: begin
            rv_d = 1'b0;
            if (any_valid) begin
               req_d   = arb_bus.request_packed_in[int'(sel)*W +: W];
               rv_d    = 1'b1;
               grant_d = sel;
            end
         end
         ST_ISSUE: begin
            if (arb_bus.issue_ack_in) begin
               rv_d           = 1'b0;
               ack_d          = '0;
               ack_d[grant_q] = 1'b1;
               last_ptr_d     = grant_q;
            end
         end
         ST_ACK: begin
            ack_d = '0;
         end
         default: begin
            rv_d  = 1'b0;
            ack_d = '0;
         end
      endcase
      busy_d = (state_d == ST_ISSUE) || (state_d == ST_ACK);
   end

   assign arb_bus.request_out          = req_q;
   assign arb_bus.request_valid_out    = rv_q;
   assign arb_bus.issue_ack_packed_out = ack_q;
   assign arb_bus.grant_index_out      = grant_q;
   assign arb_bus.busy_out             = busy_q;

endmodule

// File: tb/tb_fifo_request_arbiter.sv
// Directed bench for fifo_request_arbiter with a behavioural 16-deep FIFO.
module tb_fifo_request_arbiter;

   localparam int N      = 4;
   localparam int PW     = 2;
   localparam int W      = 64;
   localparam int QDEPTH = 16;

   logic clk_in   = 1'b0;
   logic reset_in = 1'b0;
   always #5 clk_in = ~clk_in;

   fifo_request_arbiter_if #(
      .NUM_REQUESTER               (N),
      .REQUESTER_PTR_WIDTH_IN_BITS (PW),
      .SINGLE_ENTRY_WIDTH_IN_BITS  (W)
   ) bus ();

   fifo_request_arbiter #(
      .NUM_REQUESTER               (N),
      .REQUESTER_PTR_WIDTH_IN_BITS (PW),
      .SINGLE_ENTRY_WIDTH_IN_BITS  (W)
   ) dut (
      .clk_in   (clk_in),
      .reset_in (reset_in),
      .arb_bus  (bus)
   );

   logic         ack_en     = 1'b0;
   logic         ack_force  = 1'b0;
   logic         fifo_full  = 1'b0;
   logic         fifo_clear = 1'b0;
   logic         pop_req    = 1'b0;
   logic [W-1:0] fifo_q[$];
   logic [W-1:0] popped     = '0;
   int           ack_count[N];
   int           multi_ack_cnt = 0;
   int           checks   = 0;
   int           failures = 0;

   assign bus.issue_ack_in = ack_force | (ack_en & bus.request_valid_out & ~fifo_full);

   always @(posedge clk_in) begin
      if (fifo_clear) begin
         fifo_q.delete();
      end else begin
         if (pop_req && fifo_q.size() > 0) popped = fifo_q.pop_front();
         if (bus.request_valid_out && bus.issue_ack_in) fifo_q.push_back(bus.request_out);
      end
      fifo_full <= (fifo_q.size() >= QDEPTH);
   end

   always @(posedge clk_in) begin
      for (int i = 0; i < N; i++) if (bus.issue_ack_packed_out[i]) ack_count[i]++;
      if ($countones(bus.issue_ack_packed_out) > 1) multi_ack_cnt++;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_data(input int i, input logic [W-1:0] v);
      bus.request_packed_in[i*W +: W] = v;
   endtask

   task automatic apply_reset();
      reset_in                    = 1'b0;
      bus.request_valid_packed_in = '0;
      ack_en                      = 1'b0;
      ack_force                   = 1'b0;
      pop_req                     = 1'b0;
      fifo_clear                  = 1'b1;
      tick();
      tick();
      fifo_clear = 1'b0;
      reset_in   = 1'b1;
   endtask

   task automatic test_reset();
      reset_in = 1'b0;
      for (int i = 0; i < N; i++) set_data(i, 64'h100 + 64'(i));
      bus.request_valid_packed_in = '1;
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++;
         if ({bus.request_valid_out, bus.issue_ack_packed_out, bus.busy_out,
              bus.grant_index_out, bus.request_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs cycle=%0d rv=%b ack=%b busy=%b grant=%0d req=%h required all zero",
                     c, bus.request_valid_out, bus.issue_ack_packed_out, bus.busy_out,
                     bus.grant_index_out, bus.request_out);
         end
      end
      reset_in = 1'b1;
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.grant_index_out !== 2'd0 ||
          bus.request_out !== 64'h100 || bus.busy_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant rv=%b grant=%0d req=%h busy=%b required rv=1 grant=0 req=100 busy=1",
                  bus.request_valid_out, bus.grant_index_out, bus.request_out, bus.busy_out);
      end
      apply_reset();
   endtask

   task automatic test_ack_ignored();
      apply_reset();
      ack_force = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (bus.issue_ack_packed_out !== '0 || bus.busy_out !== 1'b0 || bus.request_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL idle_ack_ignored ack=%b busy=%b rv=%b required 0/0/0",
                     bus.issue_ack_packed_out, bus.busy_out, bus.request_valid_out);
         end
      end
      ack_force = 1'b0;
   endtask

   task automatic test_single();
      apply_reset();
      ack_en = 1'b1;
      set_data(2, 64'hFFFF_FFFF_FFFF_FFFD);
      bus.request_valid_packed_in = 4'b0100;
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.request_out !== 64'hFFFF_FFFF_FFFF_FFFD ||
          bus.grant_index_out !== 2'd2 || bus.busy_out !== 1'b1) begin
         failures++;
         $display("FAIL single_issue rv=%b req=%h grant=%0d busy=%b required 1/fffffffffffffffd/2/1",
                  bus.request_valid_out, bus.request_out, bus.grant_index_out, bus.busy_out);
      end
      tick();
      bus.request_valid_packed_in = '0;
      checks++;
      if (bus.issue_ack_packed_out !== 4'b0100 || bus.request_valid_out !== 1'b0 || bus.busy_out !== 1'b1) begin
         failures++;
         $display("FAIL single_ack ack=%b rv=%b busy=%b required 0100/0/1",
                  bus.issue_ack_packed_out, bus.request_valid_out, bus.busy_out);
      end
      tick();
      checks++;
      if (bus.issue_ack_packed_out !== 4'b0000 || bus.busy_out !== 1'b0) begin
         failures++;
         $display("FAIL single_ack_end ack=%b busy=%b required 0000/0",
                  bus.issue_ack_packed_out, bus.busy_out);
      end
      tick();
      checks++;
      if (fifo_q.size() != 1 || bus.request_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL single_fifo size=%0d rv=%b required size=1 rv=0", fifo_q.size(), bus.request_valid_out);
      end else begin
         checks++;
         if (fifo_q[0] !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            failures++;
            $display("FAIL single_fifo_data got=%h required fffffffffffffffd", fifo_q[0]);
         end
      end
   endtask

   task automatic test_round_robin();
      int base[N];
      int cyc;
      apply_reset();
      ack_en = 1'b1;
      for (int i = 0; i < N; i++) begin
         set_data(i, 64'(i));
         base[i] = ack_count[i];
      end
      bus.request_valid_packed_in = '1;
      cyc = 0;
      while (fifo_q.size() < 8 && cyc < 60) begin
         tick();
         cyc++;
      end
      bus.request_valid_packed_in = '0;
      tick();
      tick();
      checks++;
      if (fifo_q.size() != 8 || cyc != 23) begin
         failures++;
         $display("FAIL rr_count size=%0d cycles=%0d required size=8 cycles=23", fifo_q.size(), cyc);
      end else begin
         for (int k = 0; k < 8; k++) begin
            checks++;
            if (fifo_q[k] !== 64'(k % 4)) begin
               failures++;
               $display("FAIL rr_order idx=%0d got=%h required %0d", k, fifo_q[k], k % 4);
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (ack_count[i] - base[i] != 2) begin
            failures++;
            $display("FAIL rr_acks producer=%0d got=%0d required 2", i, ack_count[i] - base[i]);
         end
      end
   endtask

   task automatic test_sparse_wrap();
      int cyc;
      apply_reset();
      ack_en = 1'b1;
      for (int i = 0; i < N; i++) set_data(i, 64'h50 + 64'(i));
      bus.request_valid_packed_in = 4'b1010;
      cyc = 0;
      while (fifo_q.size() < 3 && cyc < 30) begin
         tick();
         cyc++;
      end
      bus.request_valid_packed_in = '0;
      tick();
      tick();
      checks++;
      if (fifo_q.size() != 3) begin
         failures++;
         $display("FAIL sparse_count size=%0d required 3", fifo_q.size());
      end else begin
         checks++;
         if (fifo_q[0] !== 64'h51 || fifo_q[1] !== 64'h53 || fifo_q[2] !== 64'h51) begin
            failures++;
            $display("FAIL sparse_order got=%h,%h,%h required 51,53,51", fifo_q[0], fifo_q[1], fifo_q[2]);
         end
      end
   endtask

   task automatic test_backpressure();
      int cyc;
      int base1;
      apply_reset();
      ack_en = 1'b1;
      set_data(0, 64'hF0);
      bus.request_valid_packed_in = 4'b0001;
      cyc = 0;
      while (fifo_q.size() < QDEPTH && cyc < 100) begin
         tick();
         cyc++;
      end
      bus.request_valid_packed_in = '0;
      tick();
      tick();
      checks++;
      if (fifo_q.size() != QDEPTH || fifo_full !== 1'b1) begin
         failures++;
         $display("FAIL bp_fill size=%0d full=%b required 16/1", fifo_q.size(), fifo_full);
      end
      set_data(1, 64'h1717);
      bus.request_valid_packed_in = 4'b0010;
      base1 = ack_count[1];
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.grant_index_out !== 2'd1) begin
         failures++;
         $display("FAIL bp_grant rv=%b grant=%0d required 1/1", bus.request_valid_out, bus.grant_index_out);
      end
      for (int c = 0; c < 10; c++) begin
         tick();
         checks++;
         if (bus.request_valid_out !== 1'b1 || bus.issue_ack_packed_out !== '0) begin
            failures++;
            $display("FAIL bp_hold cycle=%0d rv=%b ack=%b required 1/0000",
                     c, bus.request_valid_out, bus.issue_ack_packed_out);
         end
      end
      pop_req = 1'b1;
      tick();
      pop_req = 1'b0;
      checks++;
      if (popped !== 64'hF0 || fifo_q.size() != QDEPTH - 1) begin
         failures++;
         $display("FAIL bp_drain popped=%h size=%0d required f0/15", popped, fifo_q.size());
      end
      tick();
      checks++;
      if (bus.issue_ack_packed_out !== 4'b0010 || bus.request_valid_out !== 1'b0 ||
          fifo_q.size() != QDEPTH || ack_count[1] != base1) begin
         failures++;
         $display("FAIL bp_accept ack=%b rv=%b size=%0d early_acks=%0d required 0010/0/16/0",
                  bus.issue_ack_packed_out, bus.request_valid_out, fifo_q.size(), ack_count[1] - base1);
      end else begin
         checks++;
         if (fifo_q[QDEPTH-1] !== 64'h1717) begin
            failures++;
            $display("FAIL bp_entry got=%h required 1717", fifo_q[QDEPTH-1]);
         end
      end
      bus.request_valid_packed_in = '0;
      tick();
      tick();
   endtask

   task automatic test_withdraw();
      apply_reset();
      set_data(3, 64'h3333);
      bus.request_valid_packed_in = 4'b1000;
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.grant_index_out !== 2'd3 || bus.request_out !== 64'h3333) begin
         failures++;
         $display("FAIL wd_grant rv=%b grant=%0d req=%h required 1/3/3333",
                  bus.request_valid_out, bus.grant_index_out, bus.request_out);
      end
      tick();
      bus.request_valid_packed_in = '0;
      set_data(3, 64'hDEAD);
      tick();
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.request_out !== 64'h3333) begin
         failures++;
         $display("FAIL wd_hold rv=%b req=%h required 1/3333", bus.request_valid_out, bus.request_out);
      end
      ack_en = 1'b1;
      tick();
      checks++;
      if (bus.issue_ack_packed_out !== 4'b1000 || bus.request_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL wd_ack ack=%b rv=%b required 1000/0", bus.issue_ack_packed_out, bus.request_valid_out);
      end
      tick();
      tick();
      checks++;
      if (fifo_q.size() != 1 || bus.request_valid_out !== 1'b0) begin
         failures++;
         $display("FAIL wd_fifo size=%0d rv=%b required 1/0", fifo_q.size(), bus.request_valid_out);
      end else begin
         checks++;
         if (fifo_q[0] !== 64'h3333) begin
            failures++;
            $display("FAIL wd_entry got=%h required 3333", fifo_q[0]);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      set_data(0, 64'hA0A0);
      bus.request_valid_packed_in = 4'b0001;
      tick();
      reset_in = 1'b0;
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b0 || bus.issue_ack_packed_out !== '0 ||
          bus.busy_out !== 1'b0 || bus.request_out !== '0) begin
         failures++;
         $display("FAIL mr_reset rv=%b ack=%b busy=%b req=%h required all zero",
                  bus.request_valid_out, bus.issue_ack_packed_out, bus.busy_out, bus.request_out);
      end
      reset_in = 1'b1;
      ack_en   = 1'b1;
      tick();
      checks++;
      if (bus.request_valid_out !== 1'b1 || bus.grant_index_out !== 2'd0 || bus.request_out !== 64'hA0A0) begin
         failures++;
         $display("FAIL mr_regrant rv=%b grant=%0d req=%h required 1/0/a0a0",
                  bus.request_valid_out, bus.grant_index_out, bus.request_out);
      end
      tick();
      bus.request_valid_packed_in = '0;
      checks++;
      if (bus.issue_ack_packed_out !== 4'b0001) begin
         failures++;
         $display("FAIL mr_ack ack=%b required 0001", bus.issue_ack_packed_out);
      end
      tick();
      tick();
      tick();
      checks++;
      if (fifo_q.size() != 1) begin
         failures++;
         $display("FAIL mr_no_dup size=%0d required 1", fifo_q.size());
      end else begin
         checks++;
         if (fifo_q[0] !== 64'hA0A0) begin
            failures++;
            $display("FAIL mr_entry got=%h required a0a0", fifo_q[0]);
         end
      end
   endtask

   initial begin
      bus.request_packed_in       = '0;
      bus.request_valid_packed_in = '0;
      test_reset();
      test_ack_ignored();
      test_single();
      test_round_robin();
      test_sparse_wrap();
      test_backpressure();
      test_withdraw();
      test_mid_reset();
      checks++;
      if (multi_ack_cnt != 0) begin
         failures++;
         $display("FAIL onehot_ack multi_cycles=%0d required 0", multi_ack_cnt);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
